// File: rtl/pc_gen.sv
// pc_gen: program-counter sequencer with valid/ready handshake, redirect
// load, FFFF->0000 wrap pulse and a modulo issue counter.
// Optional build macro PC_GEN_WRAP_HALT_EN: the wrapping fire parks the
// block in HALT until a redirect or reset.
//
// state | meaning
// IDLE  | one dead cycle after reset, nothing offered
// RUN   | out_pc offered downstream (out_valid=1)
// HALT  | parked after wrap, waiting for redirect (macro builds only)
module pc_gen #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [15:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_pc,
    output logic             wrap,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d, pc_inc;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;
    logic             pc_carry;
    logic [3:0]       grp_p;
    logic [3:0]       grp_c;

    // 16-bit incrementer, 4-bit groups with lookahead carries between groups
    always_comb begin
        grp_p  = '0;
        grp_c  = '0;
        pc_inc = '0;
        for (int g = 0; g < 4; g++) begin
            grp_p[g] = &pc_q[4*g +: 4];
        end
        grp_c[0] = 1'b1;
        grp_c[1] = grp_p[0];
        grp_c[2] = &grp_p[1:0];
        grp_c[3] = &grp_p[2:0];
        for (int g = 0; g < 4; g++) begin
            pc_inc[4*g]   = pc_q[4*g]   ^ grp_c[g];
            pc_inc[4*g+1] = pc_q[4*g+1] ^ (grp_c[g] & pc_q[4*g]);
            pc_inc[4*g+2] = pc_q[4*g+2] ^ (grp_c[g] & pc_q[4*g] & pc_q[4*g+1]);
            pc_inc[4*g+3] = pc_q[4*g+3] ^ (grp_c[g] & pc_q[4*g] & pc_q[4*g+1] & pc_q[4*g+2]);
        end
        pc_carry = &grp_p;
    end

    // next-state and outputs; out_valid depends on state only, so no input reaches it combinationally
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrap_d    = 1'b0;
        out_valid = (state_q == RUN);
        fire      = out_valid & out_ready;
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, fire};
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (fire) begin
                    pc_d = pc_inc;
                    if (pc_carry) begin
                        wrap_d = 1'b1;
`ifdef PC_GEN_WRAP_HALT_EN
                        state_d = HALT;
`else
                        state_d = RUN;
`endif
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        // redirect wins over increment and wrap; a coincident fire is still counted above
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = RUN;
            wrap_d  = 1'b0;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_pc    = pc_q;
    assign wrap      = wrap_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the PC sequencer.
module tb_pc_gen;

`ifdef PC_GEN_WRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic        wrap;
    logic [7:0]  issue_cnt;

    int n_checks;
    int n_fail;

    // behavioural model of what should be visible after each edge
    bit m_valid;
    bit m_halted;
    bit m_wrap;
    int m_pc;
    int m_cnt;

    pc_gen #(.RESET_PC(16'h0000), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .wrap(wrap),
        .issue_cnt(issue_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance one clock, updating the model from the inputs applied before the edge
    task automatic tick();
        bit fire;
        bit n_valid, n_halted, n_wrap;
        int n_pc, n_cnt;
        fire = m_valid && out_ready;
        if (rst) begin
            n_valid = 0; n_halted = 0; n_wrap = 0; n_pc = 0; n_cnt = 0;
        end else begin
            n_valid  = m_valid;
            n_halted = m_halted;
            n_pc     = m_pc;
            n_cnt    = (m_cnt + (fire ? 1 : 0)) % 256;
            n_wrap   = fire && !redirect_valid && (m_pc == 65535);
            if (redirect_valid) begin
                n_pc = int'(redirect_pc);
                n_valid = 1;
                n_halted = 0;
            end else if (fire) begin
                n_pc = (m_pc + 1) % 65536;
                if (m_pc == 65535 && HALT_EN) begin
                    n_valid = 0;
                    n_halted = 1;
                end
            end else if (!m_valid && !m_halted) begin
                n_valid = 1;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_halted = n_halted; m_wrap = n_wrap; m_pc = n_pc; m_cnt = n_cnt;
    endtask

    task automatic load_pc(input logic [15:0] pc);
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || out_pc !== 16'h0000 || wrap !== 1'b0 || issue_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got v=%0b pc=%h w=%0b cnt=%0d exp v=0 pc=0000 w=0 cnt=0",
                         i, out_valid, out_pc, wrap, issue_cnt);
            end
        end
        redirect_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got v=%0b exp v=0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_first_run got v=%0b pc=%h exp v=1 pc=0000", out_valid, out_pc);
        end
        tick();
        n_checks++;
        if (out_pc !== 16'h0001 || issue_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_second got pc=%h cnt=%0d exp pc=0001 cnt=1", out_pc, issue_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt0;
        load_pc(16'h0012);
        cnt0 = issue_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_pc !== 16'h0012 || out_valid !== 1'b1 || issue_cnt !== cnt0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%0b pc=%h cnt=%0d exp v=1 pc=0012 cnt=%0d",
                         i, out_valid, out_pc, issue_cnt, cnt0);
            end
        end
        // inputs wiggling between edges must not reach the outputs
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h7777;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0012) begin
            n_fail++;
            $display("FAIL comb_path got v=%0b pc=%h exp v=1 pc=0012", out_valid, out_pc);
        end
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if (out_pc !== 16'h0013 || issue_cnt !== cnt0 + 8'd1) begin
            n_fail++;
            $display("FAIL bp_release got pc=%h cnt=%0d exp pc=0013 cnt=%0d", out_pc, issue_cnt, cnt0 + 8'd1);
        end
    endtask

    task automatic test_redirect_fire();
        logic [7:0] cnt0;
        load_pc(16'h0040);
        cnt0 = issue_cnt;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h1230;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (out_pc !== 16'h1230 || out_valid !== 1'b1 || issue_cnt !== cnt0 + 8'd1) begin
            n_fail++;
            $display("FAIL redir_fire got v=%0b pc=%h cnt=%0d exp v=1 pc=1230 cnt=%0d",
                     out_valid, out_pc, issue_cnt, cnt0 + 8'd1);
        end
        tick();
        n_checks++;
        if (out_pc !== 16'h1230) begin
            n_fail++;
            $display("FAIL redir_hold got pc=%h exp pc=1230", out_pc);
        end
    endtask

    task automatic test_wrap();
        load_pc(16'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_pc !== 16'h0000 || wrap !== 1'b1 || out_valid !== !HALT_EN) begin
            n_fail++;
            $display("FAIL wrap_fire got v=%0b pc=%h w=%0b exp v=%0b pc=0000 w=1",
                     out_valid, out_pc, wrap, !HALT_EN);
        end
        if (HALT_EN) begin
            out_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                n_checks++;
                if (out_valid !== 1'b0 || wrap !== 1'b0 || out_pc !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL halt_hold cyc=%0d got v=%0b pc=%h w=%0b exp v=0 pc=0000 w=0",
                             i, out_valid, out_pc, wrap);
                end
            end
            redirect_valid = 1'b1;
            redirect_pc = 16'h0100;
            tick();
            redirect_valid = 1'b0;
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'h0100) begin
                n_fail++;
                $display("FAIL halt_exit got v=%0b pc=%h exp v=1 pc=0100", out_valid, out_pc);
            end
        end else begin
            tick();
            n_checks++;
            if (wrap !== 1'b0 || out_pc !== 16'h0000 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_pulse got v=%0b pc=%h w=%0b exp v=1 pc=0000 w=0", out_valid, out_pc, wrap);
            end
        end
        // redirect coinciding with the FFFF fire suppresses the wrap pulse
        load_pc(16'hFFFF);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h2222;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (wrap !== 1'b0 || out_pc !== 16'h2222 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_redir got v=%0b pc=%h w=%0b exp v=1 pc=2222 w=0", out_valid, out_pc, wrap);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] cnt0;
        load_pc(16'h0300);
        cnt0 = issue_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        n_checks++;
        if (issue_cnt !== cnt0 || out_pc !== 16'h0400) begin
            n_fail++;
            $display("FAIL cnt_wrap got cnt=%0d pc=%h exp cnt=%0d pc=0400", issue_cnt, out_pc, cnt0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_pc !== 16'h0000 || issue_cnt !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_rst got v=%0b pc=%h cnt=%0d exp v=0 pc=0000 cnt=0", out_valid, out_pc, issue_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 16'hFFFF;
                1: redirect_pc = 16'hFFFD;
                default: redirect_pc = 16'($urandom);
            endcase
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_pc !== 16'(m_pc) || wrap !== m_wrap || issue_cnt !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand cyc=%0d got v=%0b pc=%h w=%0b cnt=%0d exp v=%0b pc=%h w=%0b cnt=%0d",
                         i, out_valid, out_pc, wrap, issue_cnt, m_valid, 16'(m_pc), m_wrap, m_cnt);
            end
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        m_valid = 0; m_halted = 0; m_wrap = 0; m_pc = 0; m_cnt = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect_fire();
        test_wrap();
        test_cnt_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
